tlb: RTL and testbench

- Joint TLB serving the CP0 TLB-management interface: tlbwi/tlbwr writes, tlbr reads and tlbp probes.
- Sits beside cp0. The tlbr/tlbp results feed cp0's tlbr_op/entryhi_i/entrylo0_i/entrylo1_i/tlbp_op/index_i inputs; the write operands come from cp0's index/random/entryhi/entrylo outputs.
- Also provides two registered address-translation ports (fetch, data) to the IF/MEM stages.
- Refill/invalid/modified flags from these ports drive the TLB exception types.

---
 rtl/tlb_pkg.sv | 75 +++++++
 rtl/tlb_lookup.sv | 33 +++
 rtl/tlb.sv | 138 +++++++++++++
 tb/tb_tlb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB definitions: entry layout, CP0 field ranges, segment constants and translation helper.
package tlb_pkg;

  localparam int unsigned TLB_ENTRY_NUM = 16;

  // CP0 EntryHi / EntryLo field ranges
  localparam int unsigned EHI_VPN2_HI = 31;
  localparam int unsigned EHI_VPN2_LO = 13;
  localparam int unsigned EHI_ASID_HI = 7;
  localparam int unsigned ELO_PFN_HI  = 25;
  localparam int unsigned ELO_PFN_LO  = 6;
  localparam int unsigned ELO_C_HI    = 5;
  localparam int unsigned ELO_C_LO    = 3;
  localparam int unsigned ELO_D       = 2;
  localparam int unsigned ELO_V       = 1;
  localparam int unsigned ELO_G       = 0;

  localparam logic [2:0] SEG_KSEG0    = 3'b100;
  localparam logic [2:0] SEG_KSEG1    = 3'b101;
  localparam logic [2:0] CACHE_CACHED = 3'b011;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  localparam int unsigned TLB_ENTRY_W = $bits(tlb_entry_t);

  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        invalid;
    logic        uncached;
    logic        modified;
  } xlate_t;

  // Unmapped kseg0/kseg1 bypass the TLB; everything else needs a hit.
  function automatic xlate_t translate(input logic [31:0] va, input logic hit,
                                       input tlb_entry_t e, input logic we);
    xlate_t      r;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    r   = '0;
    pfn = va[12] ? e.pfn1 : e.pfn0;
    c   = va[12] ? e.c1   : e.c0;
    d   = va[12] ? e.d1   : e.d0;
    v   = va[12] ? e.v1   : e.v0;
    if (va[31:29] == SEG_KSEG0) begin
      r.paddr = {3'b000, va[28:0]};
    end else if (va[31:29] == SEG_KSEG1) begin
      r.paddr    = {3'b000, va[28:0]};
      r.uncached = 1'b1;
    end else if (!hit) begin
      r.miss = 1'b1;
    end else begin
      r.paddr    = {pfn, va[11:0]};
      r.uncached = (c != CACHE_CACHED);
      r.invalid  = ~v;
      r.modified = we & v & ~d;
    end
    return r;
  endfunction

endpackage

// File: rtl/tlb_lookup.sv
// Combinational VPN2/ASID match across all entries; the lowest matching index wins.
module tlb_lookup
  import tlb_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic [ENTRY_NUM-1:0][TLB_ENTRY_W-1:0] entries,
  input  logic [18:0]                           vpn2,
  input  logic [7:0]                            asid,
  output logic                                  hit,
  output logic [IDX_W-1:0]                      idx
);

  always_comb begin
    tlb_entry_t       e;
    logic [IDX_W-1:0] k;
    hit = 1'b0;
    idx = '0;
    e   = '0;
    k   = '0;
    // Scan high to low so the last assignment is the lowest matching index.
    for (int unsigned i = ENTRY_NUM; i > 0; i--) begin
      k = IDX_W'(i - 1);
      e = tlb_entry_t'(entries[k]);
      if (e.vpn2 == vpn2 && (e.g || e.asid == asid)) begin
        hit = 1'b1;
        idx = k;
      end
    end
  end

endmodule

// File: rtl/tlb.sv
// Joint TLB: CP0 tlbwi/tlbwr/tlbr/tlbp interface plus registered fetch and data translation ports.
module tlb
  import tlb_pkg::*;
#(
  parameter int unsigned TLB_ENTRY_NUM = tlb_pkg::TLB_ENTRY_NUM,
  localparam int unsigned IDX_W        = $clog2(TLB_ENTRY_NUM)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tlbwi_i,
  input  logic        tlbwr_i,
  input  logic        tlbr_i,
  input  logic        tlbp_i,
  input  logic [31:0] index_i,
  input  logic [31:0] random_i,
  input  logic [31:0] entryhi_i,
  input  logic [31:0] entrylo0_i,
  input  logic [31:0] entrylo1_i,
  output logic        tlbr_op_o,
  output logic [31:0] entryhi_o,
  output logic [31:0] entrylo0_o,
  output logic [31:0] entrylo1_o,
  output logic        tlbp_op_o,
  output logic [31:0] index_o,
  input  logic        stall_i,
  input  logic        inst_req_i,
  input  logic [31:0] inst_vaddr_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_paddr_o,
  output logic        inst_miss_o,
  output logic        inst_invalid_o,
  output logic        inst_uncached_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_vaddr_i,
  output logic        data_valid_o,
  output logic [31:0] data_paddr_o,
  output logic        data_miss_o,
  output logic        data_invalid_o,
  output logic        data_uncached_o,
  output logic        data_modified_o
);

  tlb_entry_t [TLB_ENTRY_NUM-1:0] tlb_q;
  tlb_entry_t                     wr_entry;
  tlb_entry_t                     rd_entry;

  logic             inst_hit, data_hit, prb_hit;
  logic [IDX_W-1:0] inst_idx, data_idx, prb_idx;
  xlate_t           inst_res, data_res;
  xlate_t           inst_q, data_q;
  logic             inst_valid_q, data_valid_q;
  logic             unused_bits;

  assign unused_bits = ^{index_i[31:IDX_W], random_i[31:IDX_W], entryhi_i[12:8],
                         entrylo0_i[31:26], entrylo1_i[31:26]};

  always_comb begin
    wr_entry      = '0;
    wr_entry.vpn2 = entryhi_i[EHI_VPN2_HI:EHI_VPN2_LO];
    wr_entry.asid = entryhi_i[EHI_ASID_HI:0];
    wr_entry.g    = entrylo0_i[ELO_G] & entrylo1_i[ELO_G];
    wr_entry.pfn0 = entrylo0_i[ELO_PFN_HI:ELO_PFN_LO];
    wr_entry.c0   = entrylo0_i[ELO_C_HI:ELO_C_LO];
    wr_entry.d0   = entrylo0_i[ELO_D];
    wr_entry.v0   = entrylo0_i[ELO_V];
    wr_entry.pfn1 = entrylo1_i[ELO_PFN_HI:ELO_PFN_LO];
    wr_entry.c1   = entrylo1_i[ELO_C_HI:ELO_C_LO];
    wr_entry.d1   = entrylo1_i[ELO_D];
    wr_entry.v1   = entrylo1_i[ELO_V];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tlb_q <= '0;
    end else if (tlbwi_i) begin
      tlb_q[index_i[IDX_W-1:0]] <= wr_entry;
    end else if (tlbwr_i) begin
      tlb_q[random_i[IDX_W-1:0]] <= wr_entry;
    end
  end

  assign rd_entry   = tlb_q[index_i[IDX_W-1:0]];
  assign tlbr_op_o  = tlbr_i;
  assign entryhi_o  = {rd_entry.vpn2, 5'b00000, rd_entry.asid};
  assign entrylo0_o = {6'b000000, rd_entry.pfn0, rd_entry.c0, rd_entry.d0, rd_entry.v0, rd_entry.g};
  assign entrylo1_o = {6'b000000, rd_entry.pfn1, rd_entry.c1, rd_entry.d1, rd_entry.v1, rd_entry.g};

  tlb_lookup #(.ENTRY_NUM(TLB_ENTRY_NUM), .IDX_W(IDX_W)) u_lookup_inst (
    .entries(tlb_q), .vpn2(inst_vaddr_i[31:13]), .asid(entryhi_i[7:0]),
    .hit(inst_hit), .idx(inst_idx)
  );

  tlb_lookup #(.ENTRY_NUM(TLB_ENTRY_NUM), .IDX_W(IDX_W)) u_lookup_data (
    .entries(tlb_q), .vpn2(data_vaddr_i[31:13]), .asid(entryhi_i[7:0]),
    .hit(data_hit), .idx(data_idx)
  );

  tlb_lookup #(.ENTRY_NUM(TLB_ENTRY_NUM), .IDX_W(IDX_W)) u_lookup_prb (
    .entries(tlb_q), .vpn2(entryhi_i[EHI_VPN2_HI:EHI_VPN2_LO]), .asid(entryhi_i[7:0]),
    .hit(prb_hit), .idx(prb_idx)
  );

  assign tlbp_op_o = tlbp_i;
  assign index_o   = {~prb_hit, {(31 - IDX_W){1'b0}}, prb_idx};

  assign inst_res = translate(inst_vaddr_i, inst_hit, tlb_q[inst_idx], 1'b0);
  assign data_res = translate(data_vaddr_i, data_hit, tlb_q[data_idx], data_we_i);

  // Results are cleared when no request is made so flags never linger past valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      inst_q       <= '0;
      data_q       <= '0;
    end else if (!stall_i) begin
      inst_valid_q <= inst_req_i;
      data_valid_q <= data_req_i;
      inst_q       <= inst_req_i ? inst_res : '0;
      data_q       <= data_req_i ? data_res : '0;
    end
  end

  assign inst_valid_o    = inst_valid_q;
  assign inst_paddr_o    = inst_q.paddr;
  assign inst_miss_o     = inst_q.miss;
  assign inst_invalid_o  = inst_q.invalid;
  assign inst_uncached_o = inst_q.uncached;

  assign data_valid_o    = data_valid_q;
  assign data_paddr_o    = data_q.paddr;
  assign data_miss_o     = data_q.miss;
  assign data_invalid_o  = data_q.invalid;
  assign data_uncached_o = data_q.uncached;
  assign data_modified_o = data_q.modified;

endmodule

// File: tb/tb_tlb.sv
// Scoreboard bench for tlb: directed vectors push expectations, a negedge monitor pops and compares.
module tb_tlb;

  logic        clk = 1'b0;
  logic        rst;
  logic        tlbwi, tlbwr, tlbr, tlbp;
  logic [31:0] index, random, entryhi, entrylo0, entrylo1;
  logic        tlbr_op;
  logic [31:0] entryhi_o, entrylo0_o, entrylo1_o;
  logic        tlbp_op;
  logic [31:0] index_o;
  logic        stall;
  logic        inst_req;
  logic [31:0] inst_vaddr;
  logic        inst_valid;
  logic [31:0] inst_paddr;
  logic        inst_miss, inst_invalid, inst_uncached;
  logic        data_req, data_we;
  logic [31:0] data_vaddr;
  logic        data_valid;
  logic [31:0] data_paddr;
  logic        data_miss, data_invalid, data_uncached, data_modified;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // {paddr, miss, invalid, uncached, modified}
  logic [35:0] inst_exp_q[$];
  logic [35:0] data_exp_q[$];
  logic [95:0] rd_exp_q[$];
  logic [31:0] prb_exp_q[$];

  always #5 clk = ~clk;

  tlb #(.TLB_ENTRY_NUM(16)) dut (
    .clk(clk), .rst(rst),
    .tlbwi_i(tlbwi), .tlbwr_i(tlbwr), .tlbr_i(tlbr), .tlbp_i(tlbp),
    .index_i(index), .random_i(random), .entryhi_i(entryhi),
    .entrylo0_i(entrylo0), .entrylo1_i(entrylo1),
    .tlbr_op_o(tlbr_op), .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o),
    .entrylo1_o(entrylo1_o), .tlbp_op_o(tlbp_op), .index_o(index_o),
    .stall_i(stall),
    .inst_req_i(inst_req), .inst_vaddr_i(inst_vaddr), .inst_valid_o(inst_valid),
    .inst_paddr_o(inst_paddr), .inst_miss_o(inst_miss), .inst_invalid_o(inst_invalid),
    .inst_uncached_o(inst_uncached),
    .data_req_i(data_req), .data_we_i(data_we), .data_vaddr_i(data_vaddr),
    .data_valid_o(data_valid), .data_paddr_o(data_paddr), .data_miss_o(data_miss),
    .data_invalid_o(data_invalid), .data_uncached_o(data_uncached),
    .data_modified_o(data_modified)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] xr(input logic [31:0] pa, input logic m, input logic i,
                                     input logic u, input logic d);
    return {pa, m, i, u, d};
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (inst_valid) begin
        if (inst_exp_q.size() == 0) check("inst_unexpected", 96'(inst_valid), 96'(0));
        else check("inst_xlate", 96'({inst_paddr, inst_miss, inst_invalid, inst_uncached, 1'b0}),
                   96'(inst_exp_q.pop_front()));
      end
      if (data_valid) begin
        if (data_exp_q.size() == 0) check("data_unexpected", 96'(data_valid), 96'(0));
        else check("data_xlate", 96'({data_paddr, data_miss, data_invalid, data_uncached, data_modified}),
                   96'(data_exp_q.pop_front()));
      end
      if (tlbr_op) begin
        if (rd_exp_q.size() == 0) check("tlbr_unexpected", 96'(tlbr_op), 96'(0));
        else check("tlbr_read", {entryhi_o, entrylo0_o, entrylo1_o}, rd_exp_q.pop_front());
      end
      if (tlbp_op) begin
        if (prb_exp_q.size() == 0) check("tlbp_unexpected", 96'(tlbp_op), 96'(0));
        else check("tlbp_index", 96'(index_o), 96'(prb_exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    tlbwi = 1'b0; tlbwr = 1'b0; tlbr = 1'b0; tlbp = 1'b0;
    inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
  endtask

  task automatic write(input logic wi, input logic wr, input logic [31:0] idx,
                       input logic [31:0] rnd, input logic [31:0] hi,
                       input logic [31:0] lo0, input logic [31:0] lo1);
    tlbwi = wi; tlbwr = wr; index = idx; random = rnd;
    entryhi = hi; entrylo0 = lo0; entrylo1 = lo1;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {32'(inst_valid), inst_paddr, 28'(0), inst_miss, inst_invalid, inst_uncached,
                 data_valid}, 96'(0));
    check({name, "_data"}, 96'({data_paddr, data_miss, data_invalid, data_uncached, data_modified}),
          96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; stall = 1'b0;
    tlbwi = 1'b0; tlbwr = 1'b0; tlbr = 1'b0; tlbp = 1'b0;
    index = '0; random = '0; entryhi = '0; entrylo0 = '0; entrylo1 = '0;
    inst_req = 1'b0; inst_vaddr = '0; data_req = 1'b0; data_we = 1'b0; data_vaddr = '0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst = 1'b1;

    // Cleared entries match page 0 / ASID 0 and report invalid rather than refill.
    entryhi = 32'h0; data_req = 1'b1; data_vaddr = 32'h0000_0000;
    inst_req = 1'b1; inst_vaddr = 32'h0000_1000;
    data_exp_q.push_back(xr(32'h0, 0, 1, 1, 0));
    inst_exp_q.push_back(xr(32'h0, 0, 1, 1, 0));
    step();

    write(1, 0, 32'd3, 32'd0, 32'h0040_2005, 32'h0000_1046, 32'h0000_1087);
    step();

    tlbr = 1'b1; index = 32'd3;
    rd_exp_q.push_back({32'h0040_2005, 32'h0000_1046, 32'h0000_1086});
    step();

    entryhi = 32'h0040_2005; data_req = 1'b1; data_vaddr = 32'h0040_2ABC;
    data_exp_q.push_back(xr(32'h0004_1ABC, 0, 0, 1, 0));
    step();

    entryhi = 32'h0040_2006; data_req = 1'b1; data_vaddr = 32'h0040_2ABC; tlbp = 1'b1;
    data_exp_q.push_back(xr(32'h0, 1, 0, 0, 0));
    prb_exp_q.push_back(32'h8000_0000);
    step();

    entryhi = 32'h0040_2005; tlbp = 1'b1;
    prb_exp_q.push_back(32'h0000_0003);
    step();

    // Rewrite odd half with D=0; same-cycle read and store still see the old entry.
    write(1, 0, 32'd3, 32'd0, 32'h0040_2005, 32'h0000_1046, 32'h0000_1083);
    tlbr = 1'b1;
    data_req = 1'b1; data_we = 1'b1; data_vaddr = 32'h0040_3000;
    rd_exp_q.push_back({32'h0040_2005, 32'h0000_1046, 32'h0000_1086});
    data_exp_q.push_back(xr(32'h0004_2000, 0, 0, 1, 0));
    step();

    data_req = 1'b1; data_we = 1'b1; data_vaddr = 32'h0040_3000;
    data_exp_q.push_back(xr(32'h0004_2000, 0, 0, 1, 1));
    step();

    data_req = 1'b1; data_we = 1'b0; data_vaddr = 32'h0040_3000;
    data_exp_q.push_back(xr(32'h0004_2000, 0, 0, 1, 0));
    step();

    inst_req = 1'b1; inst_vaddr = 32'hBFC0_0000;
    inst_exp_q.push_back(xr(32'h1FC0_0000, 0, 0, 1, 0));
    step();

    inst_req = 1'b1; inst_vaddr = 32'h8000_1000;
    inst_exp_q.push_back(xr(32'h0000_1000, 0, 0, 0, 0));
    step();

    // Global, cached entry via tlbwr; odd half has V=0.
    write(0, 1, 32'd0, 32'd5, 32'h0080_0000, 32'h0000_48DF, 32'h0000_4919);
    step();

    entryhi = 32'h0000_0009;
    data_req = 1'b1; data_vaddr = 32'h0080_0456;
    inst_req = 1'b1; inst_vaddr = 32'h0080_1000;
    data_exp_q.push_back(xr(32'h0012_3456, 0, 0, 0, 0));
    inst_exp_q.push_back(xr(32'h0012_4000, 0, 1, 0, 0));
    step();

    write(1, 1, 32'd2, 32'd7, 32'h00C0_0007, 32'h0000_1416, 32'h0000_1417);
    step();

    tlbr = 1'b1; index = 32'd2; entryhi = 32'h00C0_0007; tlbp = 1'b1;
    rd_exp_q.push_back({32'h00C0_0007, 32'h0000_1416, 32'h0000_1416});
    prb_exp_q.push_back(32'h0000_0002);
    step();

    tlbr = 1'b1; index = 32'd7;
    rd_exp_q.push_back(96'h0);
    step();

    // Duplicate of entry 3 at index 9: entry 3 must win.
    write(1, 0, 32'd9, 32'd0, 32'h0040_2005, 32'h0000_1DC6, 32'h0000_1DC6);
    step();

    entryhi = 32'h0040_2005; tlbp = 1'b1;
    data_req = 1'b1; data_vaddr = 32'h0040_2010;
    prb_exp_q.push_back(32'h0000_0003);
    data_exp_q.push_back(xr(32'h0004_1010, 0, 0, 1, 0));
    step();

    tlbr = 1'b1; index = 32'h0000_0019;
    rd_exp_q.push_back({32'h0040_2005, 32'h0000_1DC6, 32'h0000_1DC6});
    step();

    // Stall: result held for three stalled cycles plus the release cycle.
    data_req = 1'b1; data_vaddr = 32'h0040_2ABC;
    repeat (4) data_exp_q.push_back(xr(32'h0004_1ABC, 0, 0, 1, 0));
    step();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      data_req = 1'b1; data_vaddr = 32'h8000_0000;
      inst_req = 1'b1; inst_vaddr = 32'h0040_3000;
      step();
    end
    stall = 1'b0;
    step();
    step();

    // Reset in the middle of a cycle with a valid result pending.
    data_req = 1'b1; data_vaddr = 32'h0040_2ABC;
    inst_req = 1'b1; inst_vaddr = 32'hBFC0_0000;
    step();
    check("valid_before_reset", 96'({inst_valid, data_valid}), 96'(2'b11));
    rst = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    tlbr = 1'b1; index = 32'd3;
    rd_exp_q.push_back(96'h0);
    step();
    step();

    check("scoreboard_drain", 96'(inst_exp_q.size() + data_exp_q.size() +
                                  rd_exp_q.size() + prb_exp_q.size()), 96'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
